isqrt_iterative: RTL and testbench



---
 rtl/isqrt_pkg.sv | 14 +
 rtl/isqrt_step.sv | 31 +++
 rtl/isqrt_iterative.sv | 121 ++++++++++++
 tb/tb_isqrt_iterative.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// Shared types and widths for the iterative integer square-root unit.
package isqrt_pkg;

  localparam int unsigned ISQRT_X_W   = 32;
  localparam int unsigned ISQRT_Y_W   = 16;
  localparam int unsigned ISQRT_REM_W = 18;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } isqrt_state_t;

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit step of the bit-serial square root: consumes the two
// top operand bits and resolves one root bit.
module isqrt_step
  import isqrt_pkg::*;
(
  input  logic [ISQRT_X_W-1:0]   operand,
  input  logic [ISQRT_REM_W-1:0] rem,
  input  logic [ISQRT_Y_W-1:0]   root,
  output logic [ISQRT_X_W-1:0]   operand_nxt,
  output logic [ISQRT_REM_W-1:0] rem_nxt,
  output logic [ISQRT_Y_W-1:0]   root_nxt
);

  logic [ISQRT_REM_W-1:0] rem_sh;
  logic [ISQRT_REM_W-1:0] trial;

  // Shift in the next operand pair, then subtract the trial value if it fits.
  always_comb begin
    rem_sh      = {rem[ISQRT_REM_W-3:0], operand[ISQRT_X_W-1 -: 2]};
    trial       = {root, 2'b01};
    operand_nxt = {operand[ISQRT_X_W-3:0], 2'b00};
    if (rem_sh >= trial) begin
      rem_nxt  = rem_sh - trial;
      root_nxt = {root[ISQRT_Y_W-2:0], 1'b1};
    end else begin
      rem_nxt  = rem_sh;
      root_nxt = {root[ISQRT_Y_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/isqrt_iterative.sv
// Iterative, non-pipelined floor(sqrt(x)) responder. One request in flight;
// bits_per_cycle root bits are resolved per CALC cycle.
module isqrt_iterative
  import isqrt_pkg::*;
#(
  parameter int unsigned bits_per_cycle = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x_vld,
  input  logic [ISQRT_X_W-1:0] x,
  output logic                 y_vld,
  output logic [ISQRT_Y_W-1:0] y,
  output logic                 busy
);

  localparam int unsigned CntW = 4;

  if (bits_per_cycle != 1 && bits_per_cycle != 2 && bits_per_cycle != 4 &&
      bits_per_cycle != 8 && bits_per_cycle != 16) begin : g_bad_param
    $fatal(1, "isqrt_iterative: bits_per_cycle must be 1, 2, 4, 8 or 16");
  end

  localparam int unsigned Steps = ISQRT_Y_W / bits_per_cycle;
  localparam logic [CntW-1:0] CntLoad = CntW'(Steps - 1);

  isqrt_state_t state_q, state_d;
  logic                   load;
  logic [ISQRT_X_W-1:0]   op_q;
  logic [ISQRT_REM_W-1:0] rem_q;
  logic [ISQRT_Y_W-1:0]   root_q;
  logic [CntW-1:0]        cnt_q;
  logic [ISQRT_Y_W-1:0]   y_q;

  // Combinational chain of digit steps evaluated once per CALC cycle.
  logic [ISQRT_X_W-1:0]   op_c   [bits_per_cycle+1];
  logic [ISQRT_REM_W-1:0] rem_c  [bits_per_cycle+1];
  logic [ISQRT_Y_W-1:0]   root_c [bits_per_cycle+1];

  assign op_c[0]   = op_q;
  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;

  for (genvar i = 0; i < bits_per_cycle; i++) begin : g_step
    isqrt_step u_step (
      .operand     (op_c[i]),
      .rem         (rem_c[i]),
      .root        (root_c[i]),
      .operand_nxt (op_c[i+1]),
      .rem_nxt     (rem_c[i+1]),
      .root_nxt    (root_c[i+1])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; acceptance is only possible in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (x_vld) begin
          load    = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (x_vld) begin
          load    = 1'b1;
          state_d = StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers: load on accept, iterate in CALC, capture y on the last group.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
    end else if (load) begin
      op_q   <= x;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CntLoad;
    end else if (state_q == StCalc) begin
      op_q   <= op_c[bits_per_cycle];
      rem_q  <= rem_c[bits_per_cycle];
      root_q <= root_c[bits_per_cycle];
      if (cnt_q == '0) begin
        y_q <= root_c[bits_per_cycle];
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign y     = y_q;
  assign y_vld = (state_q == StDone);
  assign busy  = (state_q == StCalc);

endmodule

// File: tb/tb_isqrt_iterative.sv
// Directed bench for isqrt_iterative: one instance per legal bits_per_cycle,
// all sharing the same request inputs.
module tb_isqrt_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld_a [5];
  logic [15:0] y_a     [5];
  logic        busy_a  [5];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    isqrt_iterative #(
      .bits_per_cycle (1 << g)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld),
      .x     (x),
      .y_vld (y_vld_a[g]),
      .y     (y_a[g]),
      .busy  (busy_a[g])
    );
  end

  // Latency per instance: 17, 9, 5, 3, 2.
  function automatic int lat(input int k);
    int t [5] = '{17, 9, 5, 3, 2};
    return t[k];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present xv in cycle 0 to every instance; check each strobe and result.
  task automatic run_vec(input logic [31:0] xv, input logic [15:0] exp);
    x     = xv;
    x_vld = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      x_vld = 1'b0;
      chk($sformatf("busy1 x=%0h c=%0d", xv, c), 32'(busy_a[0]), 32'(c <= 16));
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("y_vld k=%0d x=%0h c=%0d", k, xv, c), 32'(y_vld_a[k]),
            32'(c == lat(k)));
        if (c == lat(k)) begin
          chk($sformatf("y k=%0d x=%0h", k, xv), 32'(y_a[k]), 32'(exp));
        end
      end
    end
    tick();
  endtask

  initial begin
    int pulses;
    rst   = 1'b1;
    x_vld = 1'b0;
    x     = '0;
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rst y_vld k=%0d", k), 32'(y_vld_a[k]), 32'd0);
      chk($sformatf("rst y k=%0d", k), 32'(y_a[k]), 32'd0);
      chk($sformatf("rst busy k=%0d", k), 32'(busy_a[k]), 32'd0);
    end
    rst = 1'b0;

    run_vec(32'd16, 16'd4);
    run_vec(32'd0, 16'd0);
    run_vec(32'd1, 16'd1);
    run_vec(32'd2, 16'd1);
    run_vec(32'd15, 16'd3);
    run_vec(32'd99, 16'd9);
    run_vec(32'd1000000, 16'd1000);
    run_vec(32'h3FFF_FFFF, 16'd32767);
    run_vec(32'h4000_0000, 16'd32768);
    run_vec(32'hFFFE_0001, 16'hFFFF);
    run_vec(32'hFFFE_0000, 16'hFFFE);
    run_vec(32'hFFFF_FFFF, 16'hFFFF);

    // Back-to-back on the 1-bit instance: second request in the DONE cycle.
    x     = 32'd9;
    x_vld = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      tick();
      x_vld = 1'b0;
      chk($sformatf("b2b y_vld c=%0d", c), 32'(y_vld_a[0]), 32'(c == 17 || c == 34));
      if (c == 17) begin
        chk("b2b y first", 32'(y_a[0]), 32'd3);
        chk("b2b busy done", 32'(busy_a[0]), 32'd0);
        x     = 32'd100;
        x_vld = 1'b1;
      end
      if (c == 18) chk("b2b busy reload", 32'(busy_a[0]), 32'd1);
      if (c == 20) chk("b2b y held", 32'(y_a[0]), 32'd3);
      if (c == 34) chk("b2b y second", 32'(y_a[0]), 32'd10);
    end

    // Request during CALC is dropped.
    x      = 32'd25;
    x_vld  = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      x_vld = 1'b0;
      if (y_vld_a[0]) pulses++;
      if (c == 17) begin
        chk("drop y_vld", 32'(y_vld_a[0]), 32'd1);
        chk("drop y", 32'(y_a[0]), 32'd5);
      end
      if (c == 5) begin
        x     = 32'd49;
        x_vld = 1'b1;
      end
    end
    chk("drop pulses", 32'(pulses), 32'd1);

    // Reset mid-operation aborts; a fresh request afterwards completes normally.
    x      = 32'hFFFF_FFFF;
    x_vld  = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      x_vld = 1'b0;
      if (y_vld_a[0]) pulses++;
      if (c == 8) begin
        chk("abort busy before rst", 32'(busy_a[0]), 32'd1);
        rst   = 1'b1;
        x_vld = 1'b1;
      end
      if (c == 9) begin
        chk("abort busy", 32'(busy_a[0]), 32'd0);
        chk("abort y cleared", 32'(y_a[0]), 32'd0);
        rst = 1'b0;
      end
      if (c == 10) begin
        x     = 32'd4;
        x_vld = 1'b1;
      end
      if (c == 27) begin
        chk("abort fresh y_vld", 32'(y_vld_a[0]), 32'd1);
        chk("abort fresh y", 32'(y_a[0]), 32'd2);
      end
    end
    chk("abort pulses", 32'(pulses), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
